uart_tx_sched: RTL and testbench

Round-robin transmit scheduler that shares one `uart_tx` byte transmitter between `NUM_REQ` requesters. It accepts a byte from one requester at a time over a valid/ready handshake and holds it on `data_in` for the full frame. It issues a single-cycle `start_tx` and waits for `tx_done` before serving the next requester. A watchdog flags frames that never complete, for example when `uart_en` is dropped mid-frame.

---
 rtl/uart_tx_sched.sv | 141 ++++++++++++++
 tb/tb_uart_tx_sched.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin scheduler sharing one uart_tx between NUM_REQ requesters
// Accepts one byte at a time, pulses tx_start, waits for tx_done; watchdog flags stuck frames.
module uart_tx_sched #(
  parameter int NUM_REQ        = 4,
  parameter int GW             = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 131071
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_done,
  output logic                 busy,
  output logic [GW-1:0]        grant_id,
  output logic                 timeout_err,
  input  logic                 err_clr
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam logic [GW-1:0] PTR_RST = GW'(NUM_REQ - 1);
  localparam logic [16:0]   WD_TERM = 17'(TIMEOUT_CYCLES - 1);

  state_e        state_q, state_d;
  logic [GW-1:0] last_ptr_q, last_ptr_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [7:0]    data_q, data_d;
  logic [16:0]   wd_q, wd_d;
  logic          err_q, err_d;
  logic          set_err;

  logic [GW-1:0] win_any, win_above, winner, cand;
  logic          any_valid, above_found;
  logic [7:0]    win_data;

  // Lowest set index above last_ptr wins; otherwise wrap to the lowest set index overall.
  always_comb begin
    win_any     = '0;
    win_above   = '0;
    any_valid   = 1'b0;
    above_found = 1'b0;
    cand        = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = GW'(i);
      if (req_valid[i]) begin
        win_any   = cand;
        any_valid = 1'b1;
        if (cand > last_ptr_q) begin
          win_above   = cand;
          above_found = 1'b1;
        end
      end
    end
    winner = above_found ? win_above : win_any;
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (GW'(i) == winner) begin
        win_data = req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    last_ptr_d = last_ptr_q;
    grant_d    = grant_q;
    data_d     = data_q;
    wd_d       = wd_q;
    set_err    = 1'b0;
    req_ready  = '0;
    tx_start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable && any_valid) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (GW'(i) == winner);
          end
          data_d     = win_data;
          grant_d    = winner;
          last_ptr_d = winner;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        tx_start = 1'b1;
        wd_d     = '0;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        // Completion takes precedence over a watchdog expiry in the same cycle.
        if (tx_done) begin
          state_d = ST_IDLE;
        end else if (wd_q == WD_TERM) begin
          set_err = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wd_d = wd_q + 17'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    err_d = set_err | (err_q & ~err_clr);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      last_ptr_q <= PTR_RST;
      grant_q    <= '0;
      data_q     <= 8'h00;
      wd_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_ptr_q <= last_ptr_d;
      grant_q    <= grant_d;
      data_q     <= data_d;
      wd_q       <= wd_d;
      err_q      <= err_d;
    end
  end

  assign tx_data     = data_q;
  assign grant_id    = grant_q;
  assign busy        = (state_q != ST_IDLE);
  assign timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - directed bench for uart_tx_sched (NUM_REQ=4, TIMEOUT_CYCLES=50)
// Per-cycle vector table followed by hand-written multi-cycle sequences.
module tb_uart_tx_sched;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        busy;
  logic [1:0]  grant_id;
  logic        timeout_err;
  logic        err_clr;

  int n_vec = 0;
  int n_bad = 0;

  uart_tx_sched #(
    .NUM_REQ(4),
    .GW(2),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .tx_done(tx_done),
    .busy(busy),
    .grant_id(grant_id),
    .timeout_err(timeout_err),
    .err_clr(err_clr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic        rst;
    logic        en;
    logic [3:0]  valid;
    logic [31:0] data;
    logic        done;
    logic        clr;
    logic [3:0]  e_ready;
    logic        e_start;
    logic [7:0]  e_data;
    logic        e_busy;
    logic [1:0]  e_gid;
    logic        e_err;
  } vec_t;

  vec_t vt [17];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; enable = 1'b0; req_valid = '0; tx_done = 1'b0; err_clr = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Returns the number of cycles stepped until tx_start is seen (bounded).
  task automatic wait_start(output int n);
    n = 0;
    do begin
      @(negedge clock);
      tx_done = 1'b0;
      err_clr = 1'b0;
      #1;
      n++;
    end while (!tx_start && n < 60);
    check("tx_start_seen", {31'b0, tx_start}, 32'd1);
  endtask

  initial begin
    int n;
    reset = 1'b1; enable = 1'b0; req_valid = '0; req_data = '0; tx_done = 1'b0; err_clr = 1'b0;

    //     rst  en   valid data           done clr  ready start data  busy gid  err
    vt[0]  = '{1'b0,1'b0,4'h0,32'h00000000,1'b0,1'b0,4'h0,1'b0,8'h00,1'b0,2'd0,1'b0};
    vt[1]  = '{1'b0,1'b1,4'h2,32'h0000A500,1'b0,1'b0,4'h2,1'b0,8'h00,1'b0,2'd0,1'b0};
    vt[2]  = '{1'b0,1'b1,4'h0,32'h00000000,1'b0,1'b0,4'h0,1'b1,8'hA5,1'b1,2'd1,1'b0};
    vt[3]  = '{1'b0,1'b1,4'h0,32'h00000000,1'b0,1'b0,4'h0,1'b0,8'hA5,1'b1,2'd1,1'b0};
    vt[4]  = '{1'b0,1'b1,4'h0,32'h00000000,1'b1,1'b0,4'h0,1'b0,8'hA5,1'b1,2'd1,1'b0};
    vt[5]  = '{1'b0,1'b1,4'h0,32'h00000000,1'b0,1'b0,4'h0,1'b0,8'hA5,1'b0,2'd1,1'b0};
    vt[6]  = '{1'b0,1'b1,4'hF,32'h13121110,1'b0,1'b0,4'h4,1'b0,8'hA5,1'b0,2'd1,1'b0};
    vt[7]  = '{1'b0,1'b1,4'hF,32'h13121110,1'b0,1'b0,4'h0,1'b1,8'h12,1'b1,2'd2,1'b0};
    vt[8]  = '{1'b0,1'b1,4'hF,32'h13121110,1'b1,1'b0,4'h0,1'b0,8'h12,1'b1,2'd2,1'b0};
    vt[9]  = '{1'b0,1'b1,4'hF,32'h13121110,1'b0,1'b0,4'h8,1'b0,8'h12,1'b0,2'd2,1'b0};
    vt[10] = '{1'b0,1'b1,4'hF,32'h13121110,1'b0,1'b0,4'h0,1'b1,8'h13,1'b1,2'd3,1'b0};
    vt[11] = '{1'b0,1'b1,4'hF,32'h13121110,1'b1,1'b0,4'h0,1'b0,8'h13,1'b1,2'd3,1'b0};
    vt[12] = '{1'b0,1'b1,4'hF,32'h13121110,1'b0,1'b0,4'h1,1'b0,8'h13,1'b0,2'd3,1'b0};
    vt[13] = '{1'b0,1'b1,4'hF,32'h13121110,1'b1,1'b0,4'h0,1'b1,8'h10,1'b1,2'd0,1'b0};
    vt[14] = '{1'b0,1'b0,4'hF,32'h13121110,1'b0,1'b0,4'h0,1'b0,8'h10,1'b1,2'd0,1'b0};
    vt[15] = '{1'b0,1'b0,4'hF,32'h13121110,1'b1,1'b0,4'h0,1'b0,8'h10,1'b1,2'd0,1'b0};
    vt[16] = '{1'b0,1'b0,4'hF,32'h13121110,1'b0,1'b1,4'h0,1'b0,8'h10,1'b0,2'd0,1'b0};

    repeat (2) @(posedge clock);
    for (int i = 0; i < 17; i++) begin
      @(negedge clock);
      reset = vt[i].rst; enable = vt[i].en; req_valid = vt[i].valid;
      req_data = vt[i].data; tx_done = vt[i].done; err_clr = vt[i].clr;
      #1;
      check($sformatf("v%0d_ready", i), {28'b0, req_ready}, {28'b0, vt[i].e_ready});
      check($sformatf("v%0d_start", i), {31'b0, tx_start}, {31'b0, vt[i].e_start});
      check($sformatf("v%0d_data", i), {24'b0, tx_data}, {24'b0, vt[i].e_data});
      check($sformatf("v%0d_busy", i), {31'b0, busy}, {31'b0, vt[i].e_busy});
      check($sformatf("v%0d_gid", i), {30'b0, grant_id}, {30'b0, vt[i].e_gid});
      check($sformatf("v%0d_err", i), {31'b0, timeout_err}, {31'b0, vt[i].e_err});
    end

    // Round-robin with tx_done 20 cycles after each tx_start
    do_reset();
    enable = 1'b1; req_valid = 4'hF; req_data = 32'h13121110;
    for (int f = 0; f < 5; f++) begin
      wait_start(n);
      if (f > 0) check($sformatf("rr%0d_gap", f), n, 32'd2);
      check($sformatf("rr%0d_gid", f), {30'b0, grant_id}, f % 4);
      check($sformatf("rr%0d_data", f), {24'b0, tx_data}, 32'h10 + (f % 4));
      repeat (20) @(negedge clock);
      tx_done = 1'b1;
    end

    // Timeout, then err_clr
    do_reset();
    enable = 1'b1; req_valid = 4'h1; req_data = 32'h00000055;
    wait_start(n);
    req_valid = 4'h0;
    n = 0;
    do begin
      @(negedge clock); #1; n++;
    end while (!timeout_err && n < 80);
    check("to_rise_cycles", n, 32'd51);
    check("to_busy", {31'b0, busy}, 32'd0);
    @(negedge clock); err_clr = 1'b1; #1;
    check("to_err_before_clr", {31'b0, timeout_err}, 32'd1);
    @(negedge clock); err_clr = 1'b0; #1;
    check("to_err_cleared", {31'b0, timeout_err}, 32'd0);

    // err_clr coinciding with the timeout event: set wins
    req_valid = 4'h1;
    wait_start(n);
    req_valid = 4'h0;
    repeat (50) @(negedge clock);
    err_clr = 1'b1;
    @(negedge clock); err_clr = 1'b0; #1;
    check("to_set_wins", {31'b0, timeout_err}, 32'd1);
    check("to_set_wins_busy", {31'b0, busy}, 32'd0);
    @(negedge clock); err_clr = 1'b1;
    @(negedge clock); err_clr = 1'b0; #1;
    check("to_clr2", {31'b0, timeout_err}, 32'd0);

    // tx_done in the 50th WAIT cycle: normal completion
    req_valid = 4'h1; req_data = 32'h0000003C;
    wait_start(n);
    req_valid = 4'h0;
    repeat (50) @(negedge clock);
    tx_done = 1'b1;
    @(negedge clock); tx_done = 1'b0; req_valid = 4'h1; req_data = 32'h000000C3; #1;
    check("col_err", {31'b0, timeout_err}, 32'd0);
    check("col_busy", {31'b0, busy}, 32'd0);
    check("col_ready", {28'b0, req_ready}, 32'h1);
    @(negedge clock); req_valid = 4'h0; #1;
    check("col_start", {31'b0, tx_start}, 32'd1);
    check("col_data", {24'b0, tx_data}, 32'hC3);

    // Enable held low, then reset during WAIT
    do_reset();
    enable = 1'b0; req_valid = 4'hF; req_data = 32'hDDCCBBAA;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock); #1;
      check("dis_ready", {28'b0, req_ready}, 32'h0);
      check("dis_busy", {31'b0, busy}, 32'd0);
    end
    @(negedge clock); enable = 1'b1; #1;
    check("en_first_ready", {28'b0, req_ready}, 32'h1);
    @(negedge clock); #1;
    check("en_first_start", {31'b0, tx_start}, 32'd1);
    check("en_first_data", {24'b0, tx_data}, 32'hAA);
    @(negedge clock); tx_done = 1'b1; #1;
    @(negedge clock); tx_done = 1'b0; #1;
    check("en_second_ready", {28'b0, req_ready}, 32'h2);
    @(negedge clock); #1;
    check("en_second_data", {24'b0, tx_data}, 32'hBB);
    check("en_second_gid", {30'b0, grant_id}, 32'd1);
    @(negedge clock); #1;
    check("wait_busy", {31'b0, busy}, 32'd1);
    @(negedge clock); reset = 1'b1; #1;
    @(negedge clock); reset = 1'b0; enable = 1'b0; #1;
    check("rst_ready", {28'b0, req_ready}, 32'h0);
    check("rst_start", {31'b0, tx_start}, 32'd0);
    check("rst_data", {24'b0, tx_data}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_gid", {30'b0, grant_id}, 32'd0);
    check("rst_err", {31'b0, timeout_err}, 32'd0);
    @(negedge clock); enable = 1'b1; #1;
    check("rst_next_ready", {28'b0, req_ready}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
